// File: rtl/burst_sequencer.sv
// burst_sequencer: control stage ahead of the SPI-SPS burst address adder.
// It accepts one burst (start address, length - 1) and walks a word counter.
// For each word it pulses the adder enable for one cycle, then holds a word
// request until the SPI engine acknowledges that word.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; an overflowing request is rejected with err
//   S_ISSUE | adder_en high for one cycle; adder captures initial_addr+counter
//   S_REQ   | word_req high until word_ack; then next word or S_DONE
//   S_DONE  | done pulse, busy still high; back to S_IDLE afterwards
//
// An abort in S_ISSUE, S_REQ or S_DONE returns to S_IDLE with an aborted
// pulse. It takes priority over a word_ack arriving in the same cycle.
module burst_sequencer #(
    parameter int ADDR_WIDTH    = 20,
    parameter int COUNTER_WIDTH = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [ADDR_WIDTH-1:0]    i_start_addr,
    input  logic [COUNTER_WIDTH-1:0] i_len_m1,
    input  logic                     i_abort,
    input  logic                     i_word_ack,
    output logic [ADDR_WIDTH-1:0]    o_initial_addr,
    output logic [COUNTER_WIDTH-1:0] o_counter,
    output logic                     o_adder_en,
    output logic                     o_word_req,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_aborted,
    output logic                     o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_REQ   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state;
    logic [ADDR_WIDTH-1:0]    r_initial_addr;
    logic [COUNTER_WIDTH-1:0] r_counter;
    logic [COUNTER_WIDTH-1:0] r_len;
    logic                     r_adder_en;
    logic                     r_word_req;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_aborted;
    logic                     r_err;

    // The last address of the burst is computed one bit wider than the
    // address bus; a carry into the top bit means the burst would run past
    // the end of the address space.
    logic [ADDR_WIDTH:0] w_end_addr;
    logic                w_overflow;

    assign w_end_addr = {1'b0, i_start_addr}
                      + {{(ADDR_WIDTH + 1 - COUNTER_WIDTH){1'b0}}, i_len_m1};
    assign w_overflow = w_end_addr[ADDR_WIDTH];

    // Sequencer FSM; every output is a register written alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_initial_addr <= '0;
            r_counter      <= '0;
            r_len          <= '0;
            r_adder_en     <= 1'b0;
            r_word_req     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_aborted      <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_adder_en <= 1'b0;
            r_word_req <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_overflow) begin
                            r_err <= 1'b1;
                        end else begin
                            r_initial_addr <= i_start_addr;
                            r_len          <= i_len_m1;
                            r_counter      <= '0;
                            r_busy         <= 1'b1;
                            r_adder_en     <= 1'b1;
                            r_state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_abort) begin
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_word_req <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_abort) begin
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (i_word_ack) begin
                        if (r_counter == r_len) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_counter  <= r_counter + COUNTER_WIDTH'(1);
                            r_adder_en <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end else begin
                        r_word_req <= 1'b1;
                    end
                end
                S_DONE: begin
                    // done was already shown during this state; abort here only
                    // adds the aborted pulse on the way back to idle.
                    if (i_abort) begin
                        r_aborted <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_initial_addr = r_initial_addr;
    assign o_counter      = r_counter;
    assign o_adder_en     = r_adder_en;
    assign o_word_req     = r_word_req;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_aborted      = r_aborted;
    assign o_err          = r_err;

endmodule
